// File: rtl/fc_feeder.sv
// Packs a byte stream of signed activations into 4-lane words for fc,
// pairing each word with its weight word from an internal memory and the bias.
module fc_feeder #(
    parameter int LANES  = 4,
    parameter int DW     = 8,
    parameter int NWORDS = 16,
    parameter int AW     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DW-1:0]         s_data,
    input  logic                  s_last,
    input  logic                  wt_we,
    input  logic [AW-1:0]         wt_addr,
    input  logic [LANES*DW-1:0]   wt_wdata,
    input  logic                  bias_we,
    input  logic [DW-1:0]         bias_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  en,
    output logic [LANES*DW-1:0]   in_vec,
    output logic [LANES*DW-1:0]   weights,
    output logic [DW-1:0]         bias,
    output logic                  m_last,
    output logic                  ovf
);

    localparam int VW = LANES * DW;
    localparam int LW = $clog2(LANES);

    typedef enum logic {
        FILL,
        SEND
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             started;
    logic [LW-1:0]    lane_cnt;
    logic [AW-1:0]    word_ptr;
    logic [VW-1:0]    fill_buf;
    logic [VW-1:0]    packed_word;
    logic [VW-1:0]    mem [NWORDS];
    logic             accept;
    logic             word_done;
    logic             ptr_at_end;

    assign accept     = s_valid & s_ready;
    assign word_done  = accept & (s_last | (lane_cnt == LW'(LANES - 1)));
    assign ptr_at_end = (word_ptr == AW'(NWORDS - 1));

    // A byte landing in lane 0 starts a fresh word, so stale upper lanes of a
    // short word never leak into the next one.
    always_comb begin
        packed_word = (lane_cnt == '0) ? '0 : fill_buf;
        for (int i = 0; i < LANES; i++) begin
            if (lane_cnt == LW'(i)) begin
                packed_word[i*DW +: DW] = s_data;
            end
        end
    end

    // started keeps s_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        en        = 1'b0;
        case (state)
            FILL: begin
                s_ready = started;
                if (word_done) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                en      = m_ready;
                if (m_ready) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt <= '0;
            word_ptr <= '0;
            fill_buf <= '0;
            in_vec   <= '0;
            weights  <= '0;
            m_last   <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (accept) begin
                fill_buf <= packed_word;
                lane_cnt <= word_done ? '0 : lane_cnt + 1'b1;
            end
            if (word_done) begin
                in_vec  <= packed_word;
                weights <= mem[word_ptr];
                m_last  <= s_last | ptr_at_end;
                if (ptr_at_end && !s_last) begin
                    ovf <= 1'b1;
                end
            end
            if (en) begin
                word_ptr <= m_last ? '0 : word_ptr + 1'b1;
            end
        end
    end

    // The capture above reads mem before this write lands, so a same-edge
    // write to the captured address yields the old word.
    always_ff @(posedge clk) begin
        if (wt_we) begin
            mem[wt_addr] <= wt_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias <= '0;
        end else if (bias_we) begin
            bias <= bias_in;
        end
    end

endmodule

// File: tb/tb_fc_feeder.sv
// Directed and randomized checks of fc_feeder against a byte-list model of
// word packing, weight lookup, vector termination and overflow.
module tb_fc_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_last;
    logic [7:0]  s_data;
    logic        wt_we;
    logic [3:0]  wt_addr;
    logic [31:0] wt_wdata;
    logic        bias_we;
    logic [7:0]  bias_in;
    logic        m_valid, m_ready, en, m_last, ovf;
    logic [31:0] in_vec, weights;
    logic [7:0]  bias;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem_m [16];
    logic [7:0]  bias_m;
    int          ptr_m;
    logic        ovf_m;
    logic [7:0]  cur [$];
    logic [31:0] exp_vec, exp_wt;
    logic        exp_last;

    fc_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .wt_we    (wt_we),
        .wt_addr  (wt_addr),
        .wt_wdata (wt_wdata),
        .bias_we  (bias_we),
        .bias_in  (bias_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .en       (en),
        .in_vec   (in_vec),
        .weights  (weights),
        .bias     (bias),
        .m_last   (m_last),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: collect bytes; a word closes at 4 bytes or on last.
    task automatic modelByte(input logic [7:0] d, input bit last, output bit done);
        cur.push_back(d);
        done = (cur.size() == 4) || last;
        if (done) begin
            exp_vec = '0;
            foreach (cur[i]) exp_vec[i*8 +: 8] = cur[i];
            exp_wt   = mem_m[ptr_m];
            exp_last = last || (ptr_m == 15);
            if (ptr_m == 15 && !last) ovf_m = 1'b1;
            ptr_m = exp_last ? 0 : ptr_m + 1;
            cur.delete();
        end
    endtask

    task automatic checkWord(input string tag);
        checkOutput({tag, "_m_valid"}, {31'b0, m_valid}, 32'd1);
        checkOutput({tag, "_s_ready"}, {31'b0, s_ready}, 32'd0);
        checkOutput({tag, "_in_vec"}, in_vec, exp_vec);
        checkOutput({tag, "_weights"}, weights, exp_wt);
        checkOutput({tag, "_m_last"}, {31'b0, m_last}, {31'b0, exp_last});
        checkOutput({tag, "_ovf"}, {31'b0, ovf}, {31'b0, ovf_m});
        checkOutput({tag, "_bias"}, {24'b0, bias}, {24'b0, bias_m});
    endtask

    task automatic consumeWord(input int stall);
        for (int i = 0; i < stall; i++) begin
            checkOutput("stall_en", {31'b0, en}, 32'd0);
            @(negedge clk);
            checkWord("stall");
        end
        m_ready = 1'b1;
        #1;
        checkOutput("handshake_en", {31'b0, en}, 32'd1);
        @(negedge clk);
        m_ready = 1'b0;
        checkOutput("after_m_valid", {31'b0, m_valid}, 32'd0);
        checkOutput("after_en", {31'b0, en}, 32'd0);
    endtask

    // Sends one byte; a negative stall leaves a completed word sitting in SEND.
    task automatic applyStimulus(input logic [7:0] d, input bit last, input int stall);
        int t;
        bit done;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        t = 0;
        while (!s_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) checkOutput("s_ready_wait", {31'b0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        modelByte(d, last, done);
        if (!done) begin
            checkOutput("fill_m_valid", {31'b0, m_valid}, 32'd0);
            return;
        end
        checkWord("word");
        if (stall >= 0) consumeWord(stall);
    endtask

    task automatic doReset();
        rst     = 1'b1;
        s_valid = 1'b0;
        wt_we   = 1'b0;
        bias_we = 1'b0;
        #1;
        checkOutput("rst_s_ready", {31'b0, s_ready}, 32'd0);
        checkOutput("rst_m_valid", {31'b0, m_valid}, 32'd0);
        checkOutput("rst_en", {31'b0, en}, 32'd0);
        checkOutput("rst_m_last", {31'b0, m_last}, 32'd0);
        checkOutput("rst_ovf", {31'b0, ovf}, 32'd0);
        checkOutput("rst_in_vec", in_vec, 32'd0);
        checkOutput("rst_weights", weights, 32'd0);
        checkOutput("rst_bias", {24'b0, bias}, 32'd0);
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("release_s_ready", {31'b0, s_ready}, 32'd0);
        @(negedge clk);
        checkOutput("run_s_ready", {31'b0, s_ready}, 32'd1);
        cur.delete();
        ptr_m  = 0;
        ovf_m  = 1'b0;
        bias_m = 8'h00;
    endtask

    task automatic writeMem(input logic [3:0] a, input logic [31:0] d);
        wt_we    = 1'b1;
        wt_addr  = a;
        wt_wdata = d;
        @(negedge clk);
        wt_we    = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic setBias(input logic [7:0] b);
        bias_in = b;
        bias_we = 1'b1;
        @(negedge clk);
        bias_we = 1'b0;
        bias_m  = b;
        checkOutput("bias_load", {24'b0, bias}, {24'b0, bias_m});
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        wt_we = 1'b0; wt_addr = '0; wt_wdata = '0;
        bias_we = 1'b0; bias_in = '0; m_ready = 1'b0;
        doReset();
        for (int a = 0; a < 16; a++) writeMem(4'(a), $urandom);

        $display("[TB] single word");
        writeMem(4'd0, 32'h02FF0001);
        setBias(8'h01);
        applyStimulus(8'd1, 1'b0, 0);
        applyStimulus(8'd2, 1'b0, 0);
        applyStimulus(8'd3, 1'b0, 0);
        applyStimulus(8'd4, 1'b1, -1);
        checkOutput("single_in_vec", in_vec, 32'h04030201);
        checkOutput("single_weights", weights, 32'h02FF0001);
        consumeWord(0);

        $display("[TB] short word");
        applyStimulus(8'd5, 1'b0, 0);
        applyStimulus(8'd6, 1'b1, -1);
        checkOutput("short_in_vec", in_vec, 32'h00000605);
        consumeWord(0);

        $display("[TB] two-word vector");
        writeMem(4'd0, 32'h11111111);
        writeMem(4'd1, 32'h22222222);
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i), i == 8, 0);
        applyStimulus(8'h7F, 1'b1, 0);

        $display("[TB] backpressure");
        applyStimulus(8'h81, 1'b0, 0);
        applyStimulus(8'h90, 1'b1, -1);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 8'hAA;
            if (i == 1) begin
                bias_in = 8'hC3;
                bias_we = 1'b1;
            end
            checkOutput("bp_en", {31'b0, en}, 32'd0);
            @(negedge clk);
            if (bias_we) begin
                bias_we = 1'b0;
                bias_m  = 8'hC3;
            end
            checkWord("bp");
        end
        s_valid = 1'b0;
        consumeWord(0);

        $display("[TB] same-edge write and capture");
        applyStimulus(8'h01, 1'b0, 0);
        applyStimulus(8'h02, 1'b1, 0);
        wt_we = 1'b1; wt_addr = 4'd0; wt_wdata = 32'hDEADBEEF;
        applyStimulus(8'h03, 1'b1, 0);
        wt_we = 1'b0;
        mem_m[0] = 32'hDEADBEEF;
        applyStimulus(8'h04, 1'b1, 0);

        $display("[TB] overflow");
        doReset();
        for (int i = 0; i < 64; i++) applyStimulus(8'($urandom), 1'b0, 0);
        checkOutput("ovf_set", {31'b0, ovf}, 32'd1);
        applyStimulus(8'h41, 1'b1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), i == 4, 0);
        checkOutput("ovf_sticky", {31'b0, ovf}, 32'd1);

        $display("[TB] reset mid-operation");
        applyStimulus(8'h21, 1'b0, 0);
        applyStimulus(8'h22, 1'b0, 0);
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'h30 + i), 1'b0, (i == 3) ? -1 : 0);
        m_ready = 1'b1;
        doReset();
        for (int i = 9; i <= 12; i++) applyStimulus(8'(i), i == 12, (i == 12) ? -1 : 0);
        checkOutput("rst_resume_in_vec", in_vec, 32'h0C0B0A09);
        checkOutput("rst_resume_weights", weights, mem_m[0]);
        consumeWord(0);

        $display("[TB] random vectors");
        for (int v = 0; v < 30; v++) begin
            int len;
            len = $urandom_range(1, 20);
            if ($urandom_range(0, 2) == 0) setBias(8'($urandom));
            if ($urandom_range(0, 1) == 0) writeMem(4'($urandom), $urandom);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                if ($urandom_range(0, 7) == 0) writeMem(4'($urandom), $urandom);
                applyStimulus(8'($urandom), i == len - 1, $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fc_feeder.md
# fc_feeder

Stream-to-vector front end for the `fc` layer: accepts signed 8-bit activations one per cycle over a valid/ready handshake, packs them four at a time into the 32-bit `in_vec` word `fc` consumes, and presents each word with its matching 32-bit weight word and the 8-bit bias. Weight words are held in an internal memory that is loaded through a write port. The block sits between the flatten/pool output stream and `fc`, and drives the `fc` enable.

## Interface

**Parameters**
- `LANES`, 4: activations per packed word. Fixed at 4 to match `fc`.
- `DW`, 8: activation, weight and bias width.
- `NWORDS`, 16: weight-memory depth in packed words; also the maximum number of words per vector.
- `AW`, 4: weight address width, equal to clog2(`NWORDS`).

**Ports**
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `s_valid`, input, 1: activation byte valid.
- `s_ready`, output, 1: block can accept a byte.
- `s_data`, input, 8: signed activation.
- `s_last`, input, 1: marks the final byte of a vector.
- `wt_we`, input, 1: weight-memory write enable.
- `wt_addr`, input, AW: weight-memory write address.
- `wt_wdata`, input, 32: packed weight word; lane0 in bits [7:0].
- `bias_we`, input, 1: bias register load strobe.
- `bias_in`, input, 8: signed bias value.
- `m_valid`, output, 1: packed word presented.
- `m_ready`, input, 1: `fc` accepts the word.
- `en`, output, 1: `fc` enable, equal to `m_valid & m_ready`.
- `in_vec`, output, 32: packed activations; lane0 in bits [7:0].
- `weights`, output, 32: weight word for the current word index.
- `bias`, output, 8: current bias register.
- `m_last`, output, 1: the presented word is the last word of its vector.
- `ovf`, output, 1: sticky flag, set when a vector is truncated.

## Operation

- The controller has two states.
  - FILL: `s_ready` = 1. Each accepted byte is written into lane `lane_cnt`, and `lane_cnt` increments.
  - SEND: `s_ready` = 0 and `m_valid` = 1. Outputs are frozen until `m_ready` is high.
- FILL to SEND happens on the edge that accepts the 4th byte, or any byte with `s_last` = 1.
  - Lanes not written in a short word are forced to 0. A zero activation contributes nothing to the `fc` sum.
- On that same edge:
  - `weights` <= `mem[word_ptr]`.
  - `m_last` <= `s_last` OR (`word_ptr` == `NWORDS`-1).
  - `lane_cnt` <= 0.
- SEND to FILL happens on the edge where `m_ready` = 1.
  - If `m_last` = 1, `word_ptr` <= 0; otherwise `word_ptr` increments.
- Truncation: if the word at `word_ptr` = `NWORDS`-1 completes without `s_last`:
  - `m_last` is forced to 1 and `ovf` is set.
  - Following bytes start a new vector at `word_ptr` 0.
  - `ovf` is cleared only by `rst`.
- Weight memory: synchronous write on `wt_we`. The read is registered and captured only at the FILL-to-SEND edge.
  - A write and a capture to the same address on the same edge: the capture gets the old data.
  - Writes during a vector are legal, but only affect words not yet captured.
- `bias_we` loads `bias` on the next edge and may occur at any time. A word in SEND shows the new bias one cycle after the load.
- No arithmetic is done here. Bytes and weights pass through bit-exact, with no sign extension.

## Timing

- Reset values, while `rst` is high and until the first edge after release:
  - `s_ready` = 0.
  - `m_valid` = `en` = `m_last` = `ovf` = 0.
  - `in_vec` = `weights` = 0 and `bias` = 0.
  - State FILL, `lane_cnt` = 0, `word_ptr` = 0.
  - Memory contents are not reset.
- `s_ready` = 1 from the first cycle after `rst` deasserts.
- Reset mid-vector discards the partial word and any word in SEND. No `en` pulse is produced from the discarded data.
- Latency: `m_valid` rises in the cycle after the edge that accepted the completing byte. `in_vec`, `weights` and `m_last` are valid in that same cycle.
- `en` is combinational from `m_valid & m_ready`. It is high for exactly one cycle per word when `m_ready` is held high.
- Under backpressure (`m_ready` low), all `m*` outputs hold stable and `s_ready` stays 0.
- Throughput is one 4-lane word per 5 cycles at best: 4 fill cycles plus 1 send cycle.
- `s_valid` while `s_ready` = 0 is ignored. The upstream source must hold its byte until it is accepted.

## Test plan

- **Single word.** Load `mem[0]` = 32'h02FF0001 and `bias` = 1. Send bytes 1, 2, 3, 4 with `s_last` on the 4th.
  - Expect `in_vec` = 32'h04030201, `weights` = 32'h02FF0001, `bias` = 8'h01, `m_last` = 1, and one `en` pulse.
  - The `fc` output is 7.
- **Short word.** Send bytes 5, 6 with `s_last` on the 6.
  - Expect `in_vec` = 32'h00000605, `m_last` = 1, and `m_valid` on the cycle after byte 6.
- **Two-word vector.** Use `mem[0]` = 32'h11111111 and `mem[1]` = 32'h22222222. Send bytes 1..8 with `s_last` on the 8.
  - Word 1: `weights` 32'h11111111, `m_last` 0.
  - Word 2: `in_vec` 32'h08070605, `weights` 32'h22222222, `m_last` 1.
  - The next vector uses `mem[0]` again.
- **Backpressure.** Hold `m_ready` low for 3 cycles after a word completes.
  - `in_vec`, `weights` and `m_last` stay constant, `s_ready` = 0 and `en` = 0.
  - A single `en` is seen in the cycle `m_ready` rises.
- **Overflow.** Send 64 bytes (16 words) without `s_last`.
  - Word 16 has `m_last` = 1 and `ovf` = 1 after that edge.
  - Byte 65 starts at `word_ptr` 0, and `ovf` stays 1 until `rst`.
- **Reset mid-operation.** Assert `rst` after 2 bytes, and again while in SEND.
  - All outputs go to 0 immediately, with no `en`.
  - After release, bytes 9, 10, 11, 12 + last give `in_vec` 32'h0C0B0A09 with `weights` = `mem[0]`.
